// File: rtl/control_booth_if.sv
// Bundle between the Booth sequencer, its requester and the radix-2 Booth datapath.
// The slave side is the sequencer; the master side is whatever drives requests and the datapath.
interface control_booth_if;
   logic       start;
   logic [2:0] multiplicador_in;
   logic [2:0] multiplicando_in;
   logic [1:0] q;
   logic [5:0] resultado;
   logic [2:0] multiplicador;
   logic [2:0] multiplicando;
   logic       limpiaA;
   logic       cargaA;
   logic       cargaQ;
   logic       cargaM;
   logic       resta;
   logic       desp;
   logic       ocupado;
   logic       fin;
   logic [5:0] producto;

   modport slave (
      input  start, multiplicador_in, multiplicando_in, q, resultado,
      output multiplicador, multiplicando, limpiaA, cargaA, cargaQ, cargaM,
             resta, desp, ocupado, fin, producto
   );

   modport master (
      output start, multiplicador_in, multiplicando_in, q, resultado,
      input  multiplicador, multiplicando, limpiaA, cargaA, cargaQ, cargaM,
             resta, desp, ocupado, fin, producto
   );
endinterface

// File: rtl/control_booth.sv
// Sequencer for a 3-bit radix-2 Booth multiplier datapath: latches operands, steps
// INIT / EVAL / SHIFT through N_ITER iterations and registers the signed product.
module control_booth #(
   parameter int N_ITER = 3
) (
   input  logic           clk,
   input  logic           reset_n,
   control_booth_if.slave bus
);

   typedef enum logic [2:0] {IDLE, INIT, EVAL, SHIFT, DONE} state_t;

   state_t     state;
   logic [1:0] cnt;
   logic [1:0] cnt_next;

   logic limpia_a, carga_a, carga_q, carga_m, resta, desp;

   assign cnt_next = cnt + 2'd1;

   // NOTE: state and registered outputs use non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         cnt               <= 2'd0;
         bus.fin           <= 1'b0;
         bus.producto      <= 6'd0;
         bus.multiplicador <= 3'd0;
         bus.multiplicando <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.multiplicador <= bus.multiplicador_in;
                  bus.multiplicando <= bus.multiplicando_in;
                  bus.fin           <= 1'b0;
                  cnt               <= 2'd0;
                  state             <= INIT;
               end
            end
            INIT:  state <= EVAL;
            EVAL:  state <= SHIFT;
            SHIFT: begin
               cnt   <= cnt_next;
               state <= (cnt_next == 2'(N_ITER)) ? DONE : EVAL;
            end
            DONE: begin
               bus.producto <= bus.resultado;
               bus.fin      <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Controls decode straight from the state register (and q in EVAL), so the
   // asynchronous reset forces them low without waiting for a clock.
   // NOTE: every output gets a default first, so no path leaves a latch behind.
   always_comb begin
      limpia_a = 1'b0;
      carga_a  = 1'b0;
      carga_q  = 1'b0;
      carga_m  = 1'b0;
      resta    = 1'b0;
      desp     = 1'b0;
      case (state)
         INIT: begin
            limpia_a = 1'b1;
            carga_q  = 1'b1;
            carga_m  = 1'b1;
         end
         EVAL: begin
            case (bus.q)
               2'b10: begin
                  carga_a = 1'b1;
                  resta   = 1'b1;
               end
               2'b01: carga_a = 1'b1;
               default: ;
            endcase
         end
         SHIFT:   desp = 1'b1;
         default: ;
      endcase
   end

   assign bus.limpiaA = limpia_a;
   assign bus.cargaA  = carga_a;
   assign bus.cargaQ  = carga_q;
   assign bus.cargaM  = carga_m;
   assign bus.resta   = resta;
   assign bus.desp    = desp;
   assign bus.ocupado = (state != IDLE);

endmodule
